// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axi_sram_slave
//  Brief    : AXI-style burst slave fronting a word-addressed SRAM. Independent
//             read (AR/R) and write (AW/W/B) channels, INCR bursts of 4-byte
//             beats wrapping modulo DEPTH, byte strobes, SLVERR on
//             out-of-range start addresses or write length mismatch.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_sram_slave #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    // read address channel
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic        arvalid,
    output logic        arready,
    // read data channel
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    // write address channel
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic        awvalid,
    output logic        awready,
    // write data channel
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    // write response channel
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int          c_AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0] c_DEPTH_W = 30'(DEPTH);
    localparam logic [1:0]  c_OKAY    = 2'b00;
    localparam logic [1:0]  c_SLVERR  = 2'b10;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    // Backing store; deliberately not reset so contents survive resetn.
    logic [31:0] r_mem [DEPTH];

    // Byte-offset bits are ignored: transfer size is fixed at one word.
    logic w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^{araddr[1:0], awaddr[1:0]};

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rstate_t          r_rstate;
    rstate_t          w_rstate_nxt;
    logic [c_AW-1:0]  r_ridx;      // index of the word to load on next beat
    logic [7:0]       r_rlen;
    logic [7:0]       r_rbeat;     // beat number currently presented
    logic             r_rerr;

    logic             w_ar_hs;
    logic             w_r_hs;
    logic             w_ar_oor;
    logic [c_AW-1:0]  w_ar_idx;

    assign w_ar_hs  = arvalid & arready;
    assign w_r_hs   = rvalid & rready;
    assign w_ar_oor = (araddr[31:2] >= c_DEPTH_W);
    assign w_ar_idx = araddr[2 +: c_AW];

    // Read state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    // Read next-state: leave IDLE on AR accept, return after the rlast beat.
    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs)          w_rstate_nxt = R_DATA;
            R_DATA:  if (w_r_hs && rlast)  w_rstate_nxt = R_IDLE;
            default:                       w_rstate_nxt = R_IDLE;
        endcase
    end

    // Registered read outputs and burst bookkeeping; memory is sampled
    // before any same-edge write lands, so a colliding read sees old data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= c_OKAY;
            rlast   <= 1'b0;
            r_ridx  <= '0;
            r_rlen  <= '0;
            r_rbeat <= '0;
            r_rerr  <= 1'b0;
        end else begin
            arready <= (w_rstate_nxt == R_IDLE);
            rvalid  <= (w_rstate_nxt == R_DATA);
            if (w_ar_hs) begin
                r_ridx  <= w_ar_idx + c_AW'(1);
                r_rlen  <= arlen;
                r_rbeat <= '0;
                r_rerr  <= w_ar_oor;
                rdata   <= w_ar_oor ? 32'd0 : r_mem[w_ar_idx];
                rresp   <= w_ar_oor ? c_SLVERR : c_OKAY;
                rlast   <= (arlen == 8'd0);
            end else if (w_r_hs && !rlast) begin
                r_ridx  <= r_ridx + c_AW'(1);
                r_rbeat <= r_rbeat + 8'd1;
                rdata   <= r_rerr ? 32'd0 : r_mem[r_ridx];
                rlast   <= ((r_rbeat + 8'd1) == r_rlen);
            end
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wstate_t          r_wstate;
    wstate_t          w_wstate_nxt;
    logic [c_AW-1:0]  r_widx;
    logic [7:0]       r_wlen;
    logic [8:0]       r_wcnt;      // beats accepted so far (saturating)
    logic             r_werr;

    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_b_hs;
    logic             w_aw_oor;
    logic             w_w_inlen;
    logic             w_mem_we;

    assign w_aw_hs   = awvalid & awready;
    assign w_w_hs    = wvalid & wready;
    assign w_b_hs    = bvalid & bready;
    assign w_aw_oor  = (awaddr[31:2] >= c_DEPTH_W);
    assign w_w_inlen = (r_wcnt <= {1'b0, r_wlen});
    // Excess beats and bursts starting out of range are swallowed.
    assign w_mem_we  = w_w_hs & w_w_inlen & ~r_werr;

    // Write state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    // Write next-state: address, data until wlast, then response.
    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs)          w_wstate_nxt = W_DATA;
            W_DATA:  if (w_w_hs && wlast)  w_wstate_nxt = W_RESP;
            W_RESP:  if (w_b_hs)           w_wstate_nxt = W_IDLE;
            default:                       w_wstate_nxt = W_IDLE;
        endcase
    end

    // Registered write handshakes, burst tracking and response code.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= c_OKAY;
            r_widx  <= '0;
            r_wlen  <= '0;
            r_wcnt  <= '0;
            r_werr  <= 1'b0;
        end else begin
            awready <= (w_wstate_nxt == W_IDLE);
            wready  <= (w_wstate_nxt == W_DATA);
            bvalid  <= (w_wstate_nxt == W_RESP);
            if (w_aw_hs) begin
                r_widx <= awaddr[2 +: c_AW];
                r_wlen <= awlen;
                r_wcnt <= '0;
                r_werr <= w_aw_oor;
            end else if (w_w_hs) begin
                r_widx <= r_widx + c_AW'(1);
                if (r_wcnt != 9'h1FF) begin
                    r_wcnt <= r_wcnt + 9'd1;
                end
                if (wlast) begin
                    bresp <= (r_werr || (r_wcnt != {1'b0, r_wlen})) ? c_SLVERR : c_OKAY;
                end
            end
        end
    end

    // Byte-strobed SRAM write port.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    r_mem[r_widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
